// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and ALU controls with RAW-hazard forwarding
// (EX/MEM first, then MEM/WB, then register file), plus stall-hold and flush-bubble handling.
module id_ex_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REGBITS = 5,
  parameter bit          FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [REGBITS-1:0] rs_num,
  input  logic [REGBITS-1:0] rt_num,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic               use_shamt,
  input  logic [4:0]         shamt,
  input  logic               slt,
  input  logic               sub,
  input  logic               shft,
  input  logic               math,
  input  logic [1:0]         bool,
  input  logic [REGBITS-1:0] dest_num,
  input  logic               reg_write,
  input  logic               exm_reg_write,
  input  logic [REGBITS-1:0] exm_dest,
  input  logic [WIDTH-1:0]   exm_result,
  input  logic               wb_reg_write,
  input  logic [REGBITS-1:0] wb_dest,
  input  logic [WIDTH-1:0]   wb_result,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   ex_a,
  output logic [WIDTH-1:0]   ex_b,
  output logic               ex_slt,
  output logic               ex_sub,
  output logic               ex_shft,
  output logic               ex_math,
  output logic [1:0]         ex_bool,
  output logic [REGBITS-1:0] ex_dest,
  output logic               ex_reg_write
);

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               slt_q, slt_d;
  logic               sub_q, sub_d;
  logic               shft_q, shft_d;
  logic               math_q, math_d;
  logic [1:0]         bool_q, bool_d;
  logic [REGBITS-1:0] dest_q, dest_d;
  logic               reg_write_q, reg_write_d;

  logic               rs_hit_exm, rs_hit_wb, rt_hit_exm, rt_hit_wb;
  logic [WIDTH-1:0]   fa, fb;

  // Register 0 is hardwired to zero, so a pending write to it must never be forwarded.
  always_comb begin
    rs_hit_exm = FWD_EN && exm_reg_write && (exm_dest == rs_num) && (rs_num != '0);
    rs_hit_wb  = FWD_EN && wb_reg_write  && (wb_dest  == rs_num) && (rs_num != '0);
    rt_hit_exm = FWD_EN && exm_reg_write && (exm_dest == rt_num) && (rt_num != '0);
    rt_hit_wb  = FWD_EN && wb_reg_write  && (wb_dest  == rt_num) && (rt_num != '0);
  end

  always_comb begin
    if (rs_hit_exm) begin
      fa = exm_result;
    end else if (rs_hit_wb) begin
      fa = wb_result;
    end else begin
      fa = rs_data;
    end

    if (rt_hit_exm) begin
      fb = exm_result;
    end else if (rt_hit_wb) begin
      fb = wb_result;
    end else begin
      fb = rt_data;
    end
  end

  // Capture values; an invalid decode slot loads the same all-zero bubble as a flush.
  always_comb begin
    valid_d     = 1'b0;
    a_d         = '0;
    b_d         = '0;
    slt_d       = 1'b0;
    sub_d       = 1'b0;
    shft_d      = 1'b0;
    math_d      = 1'b0;
    bool_d      = '0;
    dest_d      = '0;
    reg_write_d = 1'b0;
    if (in_valid) begin
      valid_d     = 1'b1;
      a_d         = use_shamt ? {{(WIDTH-5){1'b0}}, shamt} : fa;
      b_d         = use_imm ? imm : fb;
      slt_d       = slt;
      sub_d       = sub;
      shft_d      = shft;
      math_d      = math;
      bool_d      = bool;
      dest_d      = dest_num;
      reg_write_d = reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      slt_q       <= 1'b0;
      sub_q       <= 1'b0;
      shft_q      <= 1'b0;
      math_q      <= 1'b0;
      bool_q      <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      slt_q       <= slt_d;
      sub_q       <= sub_d;
      shft_q      <= shft_d;
      math_q      <= math_d;
      bool_q      <= bool_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_a         = a_q;
  assign ex_b         = b_q;
  assign ex_slt       = slt_q;
  assign ex_sub       = sub_q;
  assign ex_shft      = shft_q;
  assign ex_math      = math_q;
  assign ex_bool      = bool_q;
  assign ex_dest      = dest_q;
  assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model, with forwarding-enabled and forwarding-disabled instances side by side.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        slt;
    logic        sub;
    logic        shft;
    logic        math;
    logic [1:0]  bool;
    logic [4:0]  dest;
    logic        reg_write;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [4:0]  rs_num, rt_num, dest_num, exm_dest, wb_dest, shamt;
  logic [31:0] rs_data, rt_data, imm, exm_result, wb_result;
  logic        use_imm, use_shamt, slt, sub, shft, math, reg_write;
  logic        exm_reg_write, wb_reg_write;
  logic [1:0]  bool;

  out_t act, act_nf, exp_o, exp_nf;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .REGBITS(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .use_imm(use_imm), .use_shamt(use_shamt), .shamt(shamt), .slt(slt), .sub(sub),
    .shft(shft), .math(math), .bool(bool), .dest_num(dest_num), .reg_write(reg_write),
    .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
    .ex_valid(act.valid), .ex_a(act.a), .ex_b(act.b), .ex_slt(act.slt), .ex_sub(act.sub),
    .ex_shft(act.shft), .ex_math(act.math), .ex_bool(act.bool), .ex_dest(act.dest),
    .ex_reg_write(act.reg_write)
  );

  id_ex_stage #(.WIDTH(32), .REGBITS(5), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .use_imm(use_imm), .use_shamt(use_shamt), .shamt(shamt), .slt(slt), .sub(sub),
    .shft(shft), .math(math), .bool(bool), .dest_num(dest_num), .reg_write(reg_write),
    .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
    .ex_valid(act_nf.valid), .ex_a(act_nf.a), .ex_b(act_nf.b), .ex_slt(act_nf.slt),
    .ex_sub(act_nf.sub), .ex_shft(act_nf.shft), .ex_math(act_nf.math), .ex_bool(act_nf.bool),
    .ex_dest(act_nf.dest), .ex_reg_write(act_nf.reg_write)
  );

  // Value an instruction would read for a source register, given pipeline writers.
  function automatic logic [31:0] read_reg(input logic [4:0] num, input logic [31:0] rf,
                                           input bit fwd);
    if (fwd && num != 0 && exm_reg_write && exm_dest == num) return exm_result;
    if (fwd && num != 0 && wb_reg_write && wb_dest == num) return wb_result;
    return rf;
  endfunction

  function automatic out_t model_next(input out_t cur, input bit fwd);
    out_t n;
    n = '0;
    if (reset || flush) return '0;
    if (stall) return cur;
    if (!in_valid) return '0;
    n.valid     = 1'b1;
    n.a         = use_shamt ? 32'(shamt) : read_reg(rs_num, rs_data, fwd);
    n.b         = use_imm ? imm : read_reg(rt_num, rt_data, fwd);
    n.slt       = slt;
    n.sub       = sub;
    n.shft      = shft;
    n.math      = math;
    n.bool      = bool;
    n.dest      = dest_num;
    n.reg_write = reg_write;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    exp_o  = model_next(exp_o, 1'b1);
    exp_nf = model_next(exp_nf, 1'b0);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; in_valid = 0;
    rs_num = 0; rt_num = 0; dest_num = 0; exm_dest = 0; wb_dest = 0; shamt = 0;
    rs_data = 0; rt_data = 0; imm = 0; exm_result = 0; wb_result = 0;
    use_imm = 0; use_shamt = 0; slt = 0; sub = 0; shft = 0; math = 0; reg_write = 0;
    exm_reg_write = 0; wb_reg_write = 0; bool = 0;
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom); rs_num = 5'($urandom_range(0, 3)); rt_num = 5'($urandom_range(0, 3));
    exm_dest = 5'($urandom_range(0, 3)); wb_dest = 5'($urandom_range(0, 3));
    dest_num = 5'($urandom); shamt = 5'($urandom);
    rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    exm_result = $urandom; wb_result = $urandom;
    use_imm = ($urandom_range(0, 3) == 0); use_shamt = ($urandom_range(0, 3) == 0);
    slt = 1'($urandom); sub = 1'($urandom); shft = 1'($urandom); math = 1'($urandom);
    bool = 2'($urandom); reg_write = 1'($urandom);
    exm_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
  endtask

  task automatic test_reset();
    clear_inputs();
    randomize_inputs();
    in_valid = 1; reset = 1;
    step();
    step();
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_fwd: got %h want 0", act);
    end
    checks++;
    if (act_nf !== '0) begin
      errors++; $display("FAIL reset_nofwd: got %h want 0", act_nf);
    end
    reset = 0; reg_write = 1;
    step();
    checks++;
    if (act.valid !== 1'b1 || act.reg_write !== 1'b1 || act.dest !== dest_num) begin
      errors++;
      $display("FAIL first_capture: got v=%b rw=%b d=%0d want v=1 rw=1 d=%0d",
               act.valid, act.reg_write, act.dest, dest_num);
    end
    checks++;
    if (act !== exp_o) begin
      errors++; $display("FAIL first_capture_model: got %h want %h", act, exp_o);
    end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    in_valid = 1; rs_num = 3; rs_data = 32'h5;
    exm_reg_write = 1; exm_dest = 3; exm_result = 32'h11;
    wb_reg_write = 1; wb_dest = 3; wb_result = 32'h22;
    step();
    checks++;
    if (act.a !== 32'h11) begin
      errors++; $display("FAIL fwd_exm_wins: got %h want 00000011", act.a);
    end
    checks++;
    if (act_nf.a !== 32'h5) begin
      errors++; $display("FAIL nofwd_rs_data: got %h want 00000005", act_nf.a);
    end
    exm_reg_write = 0;
    step();
    checks++;
    if (act.a !== 32'h22) begin
      errors++; $display("FAIL fwd_wb: got %h want 00000022", act.a);
    end
    rt_num = 3; rt_data = 32'h9;
    step();
    checks++;
    if (act.b !== 32'h22 || act_nf.b !== 32'h9) begin
      errors++; $display("FAIL fwd_rt: got %h/%h want 00000022/00000009", act.b, act_nf.b);
    end
  endtask

  task automatic test_r0();
    clear_inputs();
    in_valid = 1; rs_num = 0; rs_data = 32'h1234;
    exm_reg_write = 1; exm_dest = 0; exm_result = 32'hFFFF;
    wb_reg_write = 1; wb_dest = 0; wb_result = 32'hBEEF;
    step();
    checks++;
    if (act.a !== 32'h1234) begin
      errors++; $display("FAIL r0_no_fwd: got %h want 00001234", act.a);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    in_valid = 1; math = 1; rs_num = 2; rs_data = 32'h7; reg_write = 1; dest_num = 5;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = $urandom; math = 0; dest_num = 5'($urandom); exm_reg_write = 1;
      exm_dest = 2; exm_result = $urandom;
      step();
      checks++;
      if (act.a !== 32'h7 || act.math !== 1'b1 || act.valid !== 1'b1 || act.dest !== 5'd5) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got a=%h math=%b v=%b d=%0d want a=7 math=1 v=1 d=5",
                 i, act.a, act.math, act.valid, act.dest);
      end
    end
    flush = 1;
    step();
    checks++;
    if (act.valid !== 1'b0 || act.reg_write !== 1'b0 || act !== '0) begin
      errors++; $display("FAIL stall_flush_bubble: got %h want 0", act);
    end
    stall = 0; flush = 0; in_valid = 0; reg_write = 1; math = 1;
    step();
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL invalid_bubble: got %h want 0", act);
    end
  endtask

  task automatic test_imm_shamt();
    clear_inputs();
    in_valid = 1; use_imm = 1; imm = 32'hFFFFFFFC; rt_num = 4; rt_data = 32'h1;
    exm_reg_write = 1; exm_dest = 4; exm_result = 32'h123;
    step();
    checks++;
    if (act.b !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL use_imm: got %h want fffffffc", act.b);
    end
    use_shamt = 1; shamt = 31; rs_num = 4; rs_data = 32'hAAAA;
    step();
    checks++;
    if (act.a !== 32'h1F) begin
      errors++; $display("FAIL use_shamt: got %h want 0000001f", act.a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      step();
      checks++;
      if (act !== exp_o) begin
        errors++; $display("FAIL random_fwd[%0d]: got %h want %h", i, act, exp_o);
      end
      checks++;
      if (act_nf !== exp_nf) begin
        errors++; $display("FAIL random_nofwd[%0d]: got %h want %h", i, act_nf, exp_nf);
      end
    end
  endtask

  initial begin
    exp_o = '0;
    exp_nf = '0;
    clear_inputs();
    test_reset();
    test_fwd_priority();
    test_r0();
    test_stall_flush();
    test_imm_shamt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
